// File: rtl/nor_mis_stim_sequencer_if.sv
// rtl/nor_mis_stim_sequencer_if.sv - host-side control and record bus of the NOR MIS stimulus sequencer
//
// master (host logic) drives: start, abort, ofs_min, ofs_max, reps
// slave (sequencer) drives:   busy, done, rec_valid, rec_ofs, rec_dir, rec_lat, rec_to
interface nor_mis_stim_sequencer_if #(
    parameter int OFS_W = 5,
    parameter int REP_W = 8,
    parameter int TS_W  = 8
);
    logic             start;
    logic             abort;
    logic [OFS_W-1:0] ofs_min;
    logic [OFS_W-1:0] ofs_max;
    logic [REP_W-1:0] reps;
    logic             busy;
    logic             done;
    logic             rec_valid;
    logic [OFS_W-1:0] rec_ofs;
    logic             rec_dir;
    logic [TS_W-1:0]  rec_lat;
    logic             rec_to;

    modport master (
        output start, abort, ofs_min, ofs_max, reps,
        input  busy, done, rec_valid, rec_ofs, rec_dir, rec_lat, rec_to
    );

    modport slave (
        input  start, abort, ofs_min, ofs_max, reps,
        output busy, done, rec_valid, rec_ofs, rec_dir, rec_lat, rec_to
    );
endinterface

// File: rtl/nor_mis_stim_sequencer.sv
// rtl/nor_mis_stim_sequencer.sv - skew-sweeping stimulus sequencer and latency recorder for the NOR2 MIS structure
//
// Ports: clk, rst_n (async active-low); host (slave modport: start/abort/ofs_min/ofs_max/reps in,
// busy/done/rec_* out); dut_out (async termination-chain output); inA1/inA2 (to myinA1/myinA2).
// Optional feature macro: NOR_MIS_TIMESTAMP_EN (synchronizer, timestamp and rec_lat/rec_to logic).
module nor_mis_stim_sequencer #(
    parameter int OFS_W = 5,
    parameter int REP_W = 8,
    parameter int GAP   = 16,
    parameter int TS_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    nor_mis_stim_sequencer_if.slave host,
    input  logic                    dut_out,
    output logic                    inA1,
    output logic                    inA2
);
    localparam int CNT_W = ($clog2(GAP) > OFS_W) ? $clog2(GAP) + 1 : OFS_W + 1;

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_LEAD, S_SKEW, S_HOLD, S_NEXT} state_t;
    state_t state, state_nx;

    logic [CNT_W-1:0]        cnt, cnt_nx;
    logic signed [OFS_W-1:0] d, d_nx, ofs_max_q, ofs_max_nx;
    logic [REP_W-1:0]        reps_q, reps_nx, rep_left, rep_left_nx;
    logic                    phase, phase_nx;    // 0 = rise phase, 1 = fall phase
    logic                    a1_nx, a2_nx;
    logic                    busy_q, busy_nx, done_q, done_nx;
    logic                    rv_q, rv_nx, rdir_q, rdir_nx, rto_q, rto_nx;
    logic [OFS_W-1:0]        rofs_q, rofs_nx;
    logic [TS_W-1:0]         rlat_q, rlat_nx;

    logic signed [CNT_W-1:0] d_wide;
    logic [CNT_W-1:0]        mag;
    logic                    empty, last_rec, hold_end, hold_rec, aborting;
    logic [TS_W-1:0]         lat_val;
    logic                    to_val;

    assign d_wide   = CNT_W'(d);
    assign mag      = d_wide[CNT_W-1] ? -d_wide : d_wide;
    assign empty    = d > ofs_max_q;    // d still holds ofs_min while in ARM
    assign last_rec = phase && (rep_left == REP_W'(1)) && (d == ofs_max_q);
    assign hold_end = (state == S_HOLD) && (cnt == '0);
    assign hold_rec = (state == S_HOLD) && (cnt == CNT_W'(1));
    assign aborting = host.abort && (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (aborting) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (host.start) state_nx = S_ARM;
                S_ARM: begin
                    if (empty)            state_nx = S_IDLE;
                    else if (cnt == '0)   state_nx = (d == '0) ? S_HOLD : S_LEAD;
                end
                S_LEAD: state_nx = (mag == CNT_W'(1)) ? S_HOLD : S_SKEW;
                S_SKEW: if (cnt == '0) state_nx = S_HOLD;
                S_HOLD: if (cnt == '0) state_nx = last_rec ? S_IDLE : S_NEXT;
                S_NEXT: state_nx = (d == '0) ? S_HOLD : S_LEAD;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // Edges are launched on entry to LEAD (leader) and HOLD (follower, or both when d==0).
    always_comb begin
        cnt_nx      = (cnt != '0) ? cnt - CNT_W'(1) : cnt;
        d_nx        = d;
        ofs_max_nx  = ofs_max_q;
        reps_nx     = reps_q;
        rep_left_nx = rep_left;
        phase_nx    = phase;
        a1_nx       = inA1;
        a2_nx       = inA2;
        busy_nx     = busy_q;
        done_nx     = 1'b0;
        rv_nx       = 1'b0;
        rofs_nx     = rofs_q;
        rdir_nx     = rdir_q;
        rlat_nx     = rlat_q;
        rto_nx      = rto_q;
        if (state == S_IDLE) begin
            if (host.start) begin
                cnt_nx      = CNT_W'(GAP - 1);
                d_nx        = host.ofs_min;
                ofs_max_nx  = host.ofs_max;
                reps_nx     = (host.reps == '0) ? REP_W'(1) : host.reps;
                rep_left_nx = reps_nx;
                phase_nx    = 1'b0;
                busy_nx     = 1'b1;
            end
        end else if (aborting || (state == S_ARM && empty) || (hold_end && last_rec)) begin
            a1_nx   = 1'b0;
            a2_nx   = 1'b0;
            busy_nx = 1'b0;
            done_nx = 1'b1;
        end else begin
            if (state_nx == S_LEAD) begin
                if (!d[OFS_W-1]) a1_nx = ~phase;
                else             a2_nx = ~phase;
            end
            if (state_nx == S_SKEW && state == S_LEAD) cnt_nx = mag - CNT_W'(2);
            if (state_nx == S_HOLD && state != S_HOLD) begin
                a1_nx  = ~phase;
                a2_nx  = ~phase;
                cnt_nx = CNT_W'(GAP - 1);
            end
            if (hold_rec) begin
                rv_nx   = 1'b1;
                rofs_nx = d;
                rdir_nx = ~phase;
                rlat_nx = lat_val;
                rto_nx  = to_val;
            end
            // The final point exits through the done branch above, so d never increments past ofs_max.
            if (hold_end) begin
                phase_nx = ~phase;
                if (phase) begin
                    if (rep_left == REP_W'(1)) begin
                        rep_left_nx = reps_q;
                        d_nx        = d + OFS_W'(1);
                    end else begin
                        rep_left_nx = rep_left - REP_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0; d <= '0; ofs_max_q <= '0; reps_q <= '0; rep_left <= '0; phase <= 1'b0;
            inA1 <= 1'b0; inA2 <= 1'b0; busy_q <= 1'b0; done_q <= 1'b0;
            rv_q <= 1'b0; rofs_q <= '0; rdir_q <= 1'b0; rlat_q <= '0; rto_q <= 1'b0;
        end else begin
            cnt <= cnt_nx; d <= d_nx; ofs_max_q <= ofs_max_nx; reps_q <= reps_nx;
            rep_left <= rep_left_nx; phase <= phase_nx;
            inA1 <= a1_nx; inA2 <= a2_nx; busy_q <= busy_nx; done_q <= done_nx;
            rv_q <= rv_nx; rofs_q <= rofs_nx; rdir_q <= rdir_nx; rlat_q <= rlat_nx; rto_q <= rto_nx;
        end
    end

`ifdef NOR_MIS_TIMESTAMP_EN
    logic [1:0]      sync;
    logic            ref_lvl, seen, differ;
    logic [TS_W-1:0] ts, lat_cap;

    assign differ = sync[1] != ref_lvl;

    // The reference is the synchronized level in the cycle just before the lead edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0; ref_lvl <= 1'b0; seen <= 1'b0; ts <= '0; lat_cap <= '0;
        end else begin
            sync <= {sync[0], dut_out};
            if ((state == S_ARM || state == S_NEXT) && (state_nx == S_LEAD || state_nx == S_HOLD))
                ref_lvl <= sync[1];
            if (state_nx == S_HOLD && state != S_HOLD) begin
                ts   <= '0;
                seen <= 1'b0;
            end else if (state == S_HOLD) begin
                if (ts != '1) ts <= ts + TS_W'(1);
                if (!seen && differ) begin
                    seen    <= 1'b1;
                    lat_cap <= ts;
                end
            end
        end
    end

    assign to_val  = !seen && !differ;
    assign lat_val = seen ? lat_cap : (differ ? ts : '1);
`else
    logic unused_dut_out;
    assign unused_dut_out = dut_out;
    assign to_val  = 1'b0;
    assign lat_val = '0;
`endif

    assign host.busy      = busy_q;
    assign host.done      = done_q;
    assign host.rec_valid = rv_q;
    assign host.rec_ofs   = rofs_q;
    assign host.rec_dir   = rdir_q;
    assign host.rec_lat   = rlat_q;
    assign host.rec_to    = rto_q;
endmodule

// File: doc/nor_mis_stim_sequencer.md
# nor_mis_stim_sequencer

Stimulus sequencer and latency recorder for the NOR2 multiple-input-switching (MIS) delay characterization structure. It drives the two pulse-shaping chain inputs with a programmable relative skew, sweeping the skew over a signed range, repeating each point and alternating rising and falling input pairs. When the timestamp feature is compiled in, it also timestamps the synchronized termination-chain output. It sits between the measurement host logic and the `myinA1`/`myinA2`/termination nets of the NOR characterization block.

## Interface
- `OFS_W`, 5: width of the signed skew values, giving a range of -16..15 cycles.
- `REP_W`, 8: width of the repetition count.
- `GAP`, 16: settle/hold cycles per phase; minimum 4.
- `TS_W`, 8: width of the latency timestamp.

- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `start` input 1: one-cycle start pulse; sampled in IDLE only.
- `abort` input 1: synchronous abort.
- `ofs_min` input OFS_W: signed first skew, in cycles. Positive means A1 leads.
- `ofs_max` input OFS_W: signed last skew, inclusive.
- `reps` input REP_W: repetitions per skew; 0 is treated as 1.
- `dut_out` input 1: termination-chain output; asynchronous, synchronized internally.
- `inA1` output 1: drives `myinA1`.
- `inA2` output 1: drives `myinA2`.
- `busy` output 1: high from start acceptance until done.
- `done` output 1: one-cycle pulse at the end of the sweep or on abort.
- `rec_valid` output 1: one-cycle record strobe. There is no backpressure.
- `rec_ofs` output OFS_W: skew of the record.
- `rec_dir` output 1: 1 = rising input pair, 0 = falling input pair.
- `rec_lat` output TS_W: cycles from the later edge to the observed `dut_out` change.
- `rec_to` output 1: timeout; no output change was seen within GAP.

## Operation
- Reset values: all outputs 0; FSM in IDLE.
- `ofs_min`, `ofs_max` and `reps` are latched on start acceptance.
- FSM states: IDLE, ARM, LEAD, SKEW, HOLD, NEXT.
- IDLE → ARM on `start`:
  - both inputs held at 0 for GAP cycles;
  - `busy` set.
  - If `ofs_min > ofs_max` (signed), skip to a `done` pulse in the next cycle; no records are emitted.
- Each repetition runs two phases: rise (both inputs 0→1), then fall (1→0).
- LEAD: the leader input toggles, where leader = A1 if d>0, A2 if d<0.
  - If d==0, both inputs toggle in the same cycle and the FSM goes directly to HOLD.
- SKEW: waits |d|-1 cycles, then the follower toggles. The inter-edge spacing is exactly |d| cycles.
- HOLD: runs for GAP cycles after the follower edge, then emits one record.
- NEXT sequencing:
  - advance the phase;
  - after the fall phase, decrement the repetition count;
  - after the last repetition, if d==ofs_max emit `done` and go to IDLE, else d+1.
  - The comparison is done before the increment, so d=15 never wraps.
- `abort` in any non-IDLE state:
  - both inputs driven to 0 next cycle;
  - no record for the interrupted phase;
  - `done` pulse, then IDLE.
- `start` while `busy` is ignored.

## Timing
- `dut_out` passes through a 2-flop synchronizer.
- A reference level is captured one cycle before the lead edge.
- The timestamp counter clears in the follower-edge cycle and increments each HOLD cycle.
- `rec_lat` is the count at the first synchronized sample differing from the reference; this includes the 2-cycle synchronizer delay.
- No change by the end of HOLD: `rec_to`=1 and `rec_lat` = all ones. The counter saturates and never wraps.
- `rec_valid` is asserted in the last HOLD cycle. `rec_*` fields are held until the next record.
- Cycles per phase = 1 + |d| + GAP. ARM occurs once per sweep.
- `done` rises 1 cycle after the final record. `busy` falls in the same cycle `done` pulses.
- Asynchronous reset mid-sweep: immediate return to all-zero outputs and IDLE.

## Configuration
- `NOR_MIS_TIMESTAMP_EN` defined: synchronizer, timestamp counter and `rec_lat`/`rec_to` logic are present as specified above.
- Undefined: `dut_out` is ignored; `rec_lat` and `rec_to` are tied to 0. `rec_valid`, `rec_ofs`, `rec_dir` and all sequencing are unchanged.

## Test plan
- ofs_min=-2, ofs_max=2, reps=1, GAP=16 → exactly 10 records, ofs -2..2 each with dir 1 then dir 0; A2 edge precedes A1 by 2 cycles at d=-2; A1 and A2 toggle in the same cycle at d=0.
- ofs_min=ofs_max=15, reps=0 → exactly 2 records at ofs 15; edge spacing is 15 cycles; `done` pulses; no wrap to -16.
- ofs_min=3, ofs_max=1 → `done` within 2 cycles of start; zero records; inputs stay 0.
- Model `dut_out` as NOR of the inputs delayed 3 cycles, d=0 → `rec_lat`=5, `rec_to`=0. With `dut_out` stuck at 0 → `rec_to`=1 and `rec_lat`=255 (TS_W=8).
- Abort during SKEW at d=4 → inputs 0 next cycle, no record for that phase, `done` pulse. A start pulse while busy is ignored.
- `rst_n` low for 1 cycle mid-HOLD → all outputs 0 immediately; a new start yields a full, correct sweep.
